// File: rtl/tcore_param.sv
// Shared core types and defaults: fetch FSM states, align-buffer request/response
// structs, and the reset/uncached address map used by the fetch front end.
package tcore_param;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] DEF_UC_BASE      = 32'h2000_0000;
    localparam logic [31:0] DEF_UC_LIMIT     = 32'h3000_0000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        MISS_WAIT = 2'd2,
        DRAIN     = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] addr;
        logic        uncached;
    } icache_req_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] blk;
    } gbuff_res_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks the fetch PC over the align buffer, splits 16/32-bit
// instructions into a one-entry output register, and handles redirects and misses.
module fetch_sequencer
    import tcore_param::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] UC_BASE      = DEF_UC_BASE,
    parameter logic [31:0] UC_LIMIT     = DEF_UC_LIMIT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic [31:0]  flush_pc_i,
    output icache_req_t  buff_req_o,
    input  gbuff_res_t   buff_res_i,
    input  logic         buffer_miss_i,
    output logic         inst_valid_o,
    input  logic         inst_ready_i,
    output logic [31:0]  inst_o,
    output logic [31:0]  inst_pc_o,
    output logic         is_comp_o,
    output logic [31:0]  miss_cycles_o,
    output fetch_state_e state_o
);

    // Handshakes: a response transfers when buff_res_i.valid is high in a cycle where
    // the sequencer can take it (FETCH/MISS_WAIT, slot free, no flush); an instruction
    // transfers to decode when inst_valid_o and inst_ready_i are both high at the edge.

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic         is_comp_q, is_comp_d;
    logic [31:0]  miss_q;

    logic        slot_free;
    logic        accept;
    logic        comp;
    logic [31:0] flush_tgt;

    assign slot_free = !inst_valid_q || inst_ready_i;
    assign accept    = buff_res_i.valid && slot_free && !flush_i &&
                       (state_q == FETCH || state_q == MISS_WAIT);
    assign comp      = (buff_res_i.blk[1:0] != 2'b11);
    assign flush_tgt = flush_pc_i & ~32'h1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        is_comp_d    = is_comp_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (flush_i) pc_d = flush_tgt;
            end
            FETCH: begin
                if (flush_i) pc_d = flush_tgt;
                else if (buffer_miss_i && !buff_res_i.valid) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                // The outstanding fill must land before redirecting, so park the target.
                if (flush_i) begin
                    state_d  = DRAIN;
                    target_d = flush_tgt;
                end else if (accept || !buffer_miss_i) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    target_d = flush_tgt;
                end else if (buff_res_i.ready) begin
                    pc_d    = target_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            inst_valid_d = 1'b0;
        end else if (accept) begin
            inst_valid_d = 1'b1;
            inst_pc_d    = pc_q;
            is_comp_d    = comp;
            inst_d       = comp ? {16'h0, buff_res_i.blk[15:0]} : buff_res_i.blk;
            pc_d         = pc_q + (comp ? 32'd2 : 32'd4);
        end else if (inst_ready_i) begin
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            target_q     <= 32'h0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            is_comp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            is_comp_q    <= is_comp_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) miss_q <= 32'h0;
        else if (state_q == MISS_WAIT) miss_q <= miss_q + 32'd1;
    end

    always_comb begin
        buff_req_o.valid    = (state_q != IDLE);
        buff_req_o.ready    = 1'b1;
        buff_req_o.addr     = pc_q;
        buff_req_o.uncached = (pc_q >= UC_BASE) && (pc_q < UC_LIMIT);
    end

    assign inst_valid_o  = inst_valid_q;
    assign inst_o        = inst_q;
    assign inst_pc_o     = inst_pc_q;
    assign is_comp_o     = is_comp_q;
    assign miss_cycles_o = miss_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, hit streams, miss, drain, stall,
// PC wrap and uncached-window boundaries, all against hand-computed values.
module tb_fetch_sequencer;
    import tcore_param::*;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [31:0]  flush_pc;
    icache_req_t  buff_req;
    gbuff_res_t   buff_res;
    logic         buffer_miss;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic         is_comp;
    logic [31:0]  miss_cycles;
    fetch_state_e state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    fetch_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .flush_pc_i    (flush_pc),
        .buff_req_o    (buff_req),
        .buff_res_i    (buff_res),
        .buffer_miss_i (buffer_miss),
        .inst_valid_o  (inst_valid),
        .inst_ready_i  (inst_ready),
        .inst_o        (inst),
        .inst_pc_o     (inst_pc),
        .is_comp_o     (is_comp),
        .miss_cycles_o (miss_cycles),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic v, input logic r, input logic [31:0] b);
        buff_res.valid = v;
        buff_res.ready = r;
        buff_res.blk   = b;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        flush_pc = 32'h0;
        buffer_miss = 1'b0;
        inst_ready = 1'b1;
        drive_res(1'b0, 1'b0, 32'h0);

        // reset state
        #12;
        check_eq("rst_state", 32'(state), 32'(IDLE));
        check_eq("rst_addr", buff_req.addr, 32'h8000_0000);
        check_eq("rst_req_valid", 32'(buff_req.valid), 32'd0);
        check_eq("rst_req_ready", 32'(buff_req.ready), 32'd1);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_miss", miss_cycles, 32'h0);
        check_eq("rst_uncached", 32'(buff_req.uncached), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check_eq("idle_to_fetch", 32'(state), 32'(FETCH));
        check_eq("fetch_req_valid", 32'(buff_req.valid), 32'd1);

        // first compressed hit at the reset vector
        drive_res(1'b1, 1'b0, 32'h0000_4501);
        tick();
        check_eq("first_valid", 32'(inst_valid), 32'd1);
        check_eq("first_pc", inst_pc, 32'h8000_0000);
        check_eq("first_comp", 32'(is_comp), 32'd1);
        check_eq("first_inst", inst, 32'h0000_4501);
        check_eq("first_next_addr", buff_req.addr, 32'h8000_0002);

        // alternating 32-bit / compressed stream, one per cycle
        exp_q.push_back(32'h8000_0002);
        exp_q.push_back(32'h8000_0006);
        exp_q.push_back(32'h8000_0008);
        exp_q.push_back(32'h8000_000C);
        for (int i = 0; i < 4; i++) begin
            drive_res(1'b1, 1'b0, (i % 2 == 0) ? 32'h0000_0013 : 32'h0000_0001);
            tick();
            check_eq("stream_valid", 32'(inst_valid), 32'd1);
            check_eq("stream_pc", inst_pc, exp_q.pop_front());
            check_eq("stream_comp", 32'(is_comp), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        drive_res(1'b0, 1'b0, 32'h0);
        tick();
        check_eq("stream_drained", 32'(inst_valid), 32'd0);
        check_eq("stream_end_addr", buff_req.addr, 32'h8000_000E);

        // miss for five cycles, then the response
        buffer_miss = 1'b1;
        tick();
        check_eq("miss_state", 32'(state), 32'(MISS_WAIT));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("miss_addr_stable", buff_req.addr, 32'h8000_000E);
        end
        buffer_miss = 1'b0;
        drive_res(1'b1, 1'b0, 32'h0000_0013);
        tick();
        check_eq("miss_count", miss_cycles, 32'd5);
        check_eq("miss_deliver_valid", 32'(inst_valid), 32'd1);
        check_eq("miss_deliver_pc", inst_pc, 32'h8000_000E);
        check_eq("miss_back_fetch", 32'(state), 32'(FETCH));
        check_eq("miss_next_addr", buff_req.addr, 32'h8000_0012);
        drive_res(1'b0, 1'b0, 32'h0);
        tick();

        // flush while a miss is outstanding
        buffer_miss = 1'b1;
        tick();
        flush = 1'b1;
        flush_pc = 32'h8000_0103;
        tick();
        flush = 1'b0;
        buffer_miss = 1'b0;
        check_eq("drain_state", 32'(state), 32'(DRAIN));
        check_eq("drain_addr_hold", buff_req.addr, 32'h8000_0012);
        check_eq("drain_miss_count", miss_cycles, 32'd6);
        drive_res(1'b1, 1'b0, 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("drain_no_valid", 32'(inst_valid), 32'd0);
            check_eq("drain_addr", buff_req.addr, 32'h8000_0012);
        end
        drive_res(1'b0, 1'b1, 32'h0);
        tick();
        check_eq("drain_exit_state", 32'(state), 32'(FETCH));
        check_eq("drain_exit_addr", buff_req.addr, 32'h8000_0102);
        drive_res(1'b0, 1'b0, 32'h0);

        // decode stall holds the output register and the PC
        inst_ready = 1'b0;
        drive_res(1'b1, 1'b0, 32'h0000_0013);
        tick();
        check_eq("stall_pc", inst_pc, 32'h8000_0102);
        drive_res(1'b1, 1'b0, 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_inst_hold", inst, 32'h0000_0013);
            check_eq("stall_pc_hold", inst_pc, 32'h8000_0102);
            check_eq("stall_addr_hold", buff_req.addr, 32'h8000_0106);
        end
        inst_ready = 1'b1;
        tick();
        check_eq("resume_valid", 32'(inst_valid), 32'd1);
        check_eq("resume_pc", inst_pc, 32'h8000_0106);
        check_eq("resume_comp", 32'(is_comp), 32'd1);
        check_eq("resume_addr", buff_req.addr, 32'h8000_0108);
        drive_res(1'b0, 1'b0, 32'h0);
        tick();
        check_eq("resume_drained", 32'(inst_valid), 32'd0);

        // flush beats a same-cycle response; then PC wraps past 2^32
        flush = 1'b1;
        flush_pc = 32'hFFFF_FFFF;
        drive_res(1'b1, 1'b0, 32'h0000_0013);
        tick();
        flush = 1'b0;
        check_eq("flush_addr", buff_req.addr, 32'hFFFF_FFFE);
        check_eq("flush_drop", 32'(inst_valid), 32'd0);
        drive_res(1'b1, 1'b0, 32'h0000_0001);
        tick();
        check_eq("wrap_pc", inst_pc, 32'hFFFF_FFFE);
        check_eq("wrap_addr", buff_req.addr, 32'h0000_0000);

        // uncached window edges
        drive_res(1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        flush_pc = 32'h1FFF_FFFF;
        tick();
        flush = 1'b0;
        check_eq("uc_below", 32'(buff_req.uncached), 32'd0);
        drive_res(1'b1, 1'b0, 32'h0000_0001);
        tick();
        drive_res(1'b0, 1'b0, 32'h0);
        check_eq("uc_base_addr", buff_req.addr, 32'h2000_0000);
        check_eq("uc_base", 32'(buff_req.uncached), 32'd1);
        flush = 1'b1;
        flush_pc = 32'h2FFF_FFFE;
        tick();
        flush = 1'b0;
        check_eq("uc_top", 32'(buff_req.uncached), 32'd1);
        drive_res(1'b1, 1'b0, 32'h0000_0001);
        tick();
        drive_res(1'b0, 1'b0, 32'h0);
        check_eq("uc_limit_addr", buff_req.addr, 32'h3000_0000);
        check_eq("uc_limit", 32'(buff_req.uncached), 32'd0);
        tick();

        // reset in the middle of a drain abandons it
        buffer_miss = 1'b1;
        tick();
        flush = 1'b1;
        flush_pc = 32'h8000_0400;
        tick();
        flush = 1'b0;
        buffer_miss = 1'b0;
        check_eq("pre_rst_state", 32'(state), 32'(DRAIN));
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_state", 32'(state), 32'(IDLE));
        check_eq("async_rst_addr", buff_req.addr, 32'h8000_0000);
        check_eq("async_rst_miss", miss_cycles, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_res(1'b0, 1'b1, 32'h0);
        tick();
        check_eq("post_rst_state", 32'(state), 32'(FETCH));
        check_eq("post_rst_addr", buff_req.addr, 32'h8000_0000);
        tick();
        check_eq("post_rst_no_target", buff_req.addr, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
